// File: rtl/aes_key_pkg.sv
// Shared constants and helpers for the AES key-expansion engine.
package aes_key_pkg;

  localparam int WORD_W = 32;
  localparam int RK_W   = 128;

  localparam logic [1:0] KS_128  = 2'b00;
  localparam logic [1:0] KS_192  = 2'b01;
  localparam logic [1:0] KS_256  = 2'b10;
  localparam logic [1:0] KS_RSVD = 2'b11;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RK_W-1:0]   rk_t;

  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd4;
      KS_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd10;
      KS_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Reserved encoding reports zero bits so callers can reject it uniformly.
  function automatic int key_bits(input logic [1:0] ks);
    case (ks)
      KS_128:  return 128;
      KS_192:  return 192;
      KS_256:  return 256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_sub_word.sv
// AES SubWord: four parallel S-box lookups, computed as GF(2^8) inverse
// (x^254) followed by the affine transform. Purely combinational.
module aes_sub_word
  import aes_key_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Addition chain for x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion (128/192/256) at one word per clock into a round-key store,
// then 1-cycle registered round-key reads in forward or reverse order.
module aes_key_schedule
  import aes_key_pkg::*;
#(
  parameter int MAX_KEY_LEN  = 256,
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_size,
  input  logic [MAX_KEY_LEN-1:0]  key,
  output logic                    busy,
  output logic                    ready,
  output logic [3:0]              nr,
  output logic                    cfg_err,
  input  logic                    rd_en,
  input  logic [3:0]              rd_round,
  input  logic                    rd_inv,
  output logic [BLOCK_LENGTH-1:0] round_key,
  output logic                    rk_valid
);

  localparam int NR_MAX = (MAX_KEY_LEN == 256) ? 14 : (MAX_KEY_LEN == 192) ? 12 : 10;
  localparam int T_MAX  = 4 * (NR_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  logic [1:0] state;
  logic [3:0] cur_nk;
  logic [3:0] cur_nr;
  logic [5:0] idx;
  logic [2:0] phase;
  logic [7:0] rcon;

  word_t w_store [T_MAX];
  word_t win [8];
  word_t key_w [8];

  logic [255:0] key_pad;
  logic         can_start, start_legal, accept, reject;
  logic [3:0]   new_nk;
  word_t        prev, oldest, sub_in, sub_out, temp, new_w;
  logic         last_word, phase_wrap;
  logic         rd_ok;
  logic [3:0]   eff;
  logic [5:0]   base;
  rk_t          rd_word;

  // Key is MSB-aligned; left-justify it into a 256-bit frame.
  assign key_pad = 256'(key) << (256 - MAX_KEY_LEN);

  always_comb begin
    for (int k = 0; k < 8; k++) key_w[k] = key_pad[255-32*k -: 32];
  end

  assign busy        = (state == ST_EXPAND);
  assign ready       = (state == ST_READY);
  assign can_start   = (state == ST_IDLE) || (state == ST_READY);
  assign start_legal = (key_size != KS_RSVD) && (key_bits(key_size) <= MAX_KEY_LEN);
  assign accept      = start && can_start && start_legal;
  assign reject      = start && can_start && !start_legal;
  assign new_nk      = nk_of(key_size);

  // Window is top-aligned: win[7] = w[i-1], w[i-Nk] sits at win[8-Nk].
  assign prev = win[7];
  always_comb begin
    case (cur_nk)
      4'd4:    oldest = win[4];
      4'd6:    oldest = win[2];
      default: oldest = win[0];
    endcase
  end

  assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = prev;
    if (phase == 3'd0)                         temp = sub_out ^ {rcon, 24'h0};
    else if (cur_nk == 4'd8 && phase == 3'd4)  temp = sub_out;
    new_w = oldest ^ temp;
  end

  assign last_word  = (idx == {cur_nr, 2'b11});
  assign phase_wrap = ({1'b0, phase} == (cur_nk - 4'd1));

  assign rd_ok   = rd_en && (state == ST_READY) && (rd_round <= nr);
  assign eff     = rd_inv ? (nr - rd_round) : rd_round;
  assign base    = {eff, 2'b00};
  assign rd_word = {w_store[base], w_store[base + 6'd1], w_store[base + 6'd2], w_store[base + 6'd3]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cfg_err   <= 1'b0;
      rk_valid  <= 1'b0;
      round_key <= '0;
      nr        <= 4'd0;
      cur_nk    <= 4'd4;
      cur_nr    <= 4'd10;
      idx       <= 6'd0;
      phase     <= 3'd0;
      rcon      <= 8'h01;
    end else begin
      cfg_err  <= reject;
      rk_valid <= rd_ok;
      if (rd_ok) round_key <= rd_word;
      case (state)
        ST_IDLE, ST_READY: begin
          if (accept) begin
            state  <= ST_EXPAND;
            nr     <= 4'd0;
            cur_nk <= new_nk;
            cur_nr <= nr_of(key_size);
            idx    <= {2'b00, new_nk};
            phase  <= 3'd0;
            rcon   <= 8'h01;
          end
        end
        ST_EXPAND: begin
          idx   <= idx + 6'd1;
          phase <= phase_wrap ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
          if (last_word) begin
            state <= ST_READY;
            nr    <= cur_nr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word store and window are deliberately unreset; ready gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < new_nk) w_store[k] <= key_w[k];
      end
      case (key_size)
        KS_128:  for (int j = 0; j < 4; j++) win[j+4] <= key_w[j];
        KS_192:  for (int j = 0; j < 6; j++) win[j+2] <= key_w[j];
        default: for (int j = 0; j < 8; j++) win[j]   <= key_w[j];
      endcase
    end else if (state == ST_EXPAND) begin
      w_store[idx] <= new_w;
      for (int j = 0; j < 7; j++) win[j] <= win[j+1];
      win[7] <= new_w;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: directed FIPS-197 vectors, scoreboard on round-key reads.
module tb_aes_key_schedule;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk;
  logic rst, start, rd_en, rd_inv;
  logic [1:0] key_size;
  logic [255:0] key;
  logic [3:0] rd_round, nr;
  logic busy, ready, cfg_err, rk_valid;
  logic [127:0] round_key;

  logic s_start, s_rd_en, s_rd_inv;
  logic [1:0] s_key_size;
  logic [127:0] s_key;
  logic [3:0] s_rd_round, s_nr;
  logic s_busy, s_ready, s_cfg_err, s_rk_valid;
  logic [127:0] s_round_key;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  int streak = 0;
  int max_streak = 0;
  logic [7:0] sbox [256];
  logic [255:0] cur_key;
  int cur_nk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_LEN(256), .BLOCK_LENGTH(128)) dut (
    .clk(clk), .rst(rst), .start(start), .key_size(key_size), .key(key),
    .busy(busy), .ready(ready), .nr(nr), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_round(rd_round), .rd_inv(rd_inv),
    .round_key(round_key), .rk_valid(rk_valid)
  );

  aes_key_schedule #(.MAX_KEY_LEN(128), .BLOCK_LENGTH(128)) dut128 (
    .clk(clk), .rst(rst), .start(s_start), .key_size(s_key_size), .key(s_key),
    .busy(s_busy), .ready(s_ready), .nr(s_nr), .cfg_err(s_cfg_err),
    .rd_en(s_rd_en), .rd_round(s_rd_round), .rd_inv(s_rd_inv),
    .round_key(s_round_key), .rk_valid(s_rk_valid)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [255:0] k, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int tot;
    rc = 8'h01;
    tot = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Monitor: every presented round key must match the oldest expectation.
  always @(negedge clk) begin
    if (rk_valid) begin
      streak++;
      if (streak > max_streak) max_streak = streak;
      if (exp_q.size() == 0) chk("rk_unexpected", 1, 0);
      else chk("rk_data", round_key, exp_q.pop_front());
    end else begin
      streak = 0;
    end
  end

  task automatic rd(input logic [3:0] r, input bit inv, input bit vld, input logic [127:0] e);
    rd_en = 1'b1;
    rd_round = r;
    rd_inv = inv;
    if (vld) exp_q.push_back(e);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_nr"}, nr, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_round_key"}, round_key, 0);
  endtask

  task automatic expand(input logic [1:0] ks, input logic [255:0] k, input int inj);
    int nk, nrr, w_exp, cnt;
    bit was_ready;
    nk = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
    nrr = nk + 6;
    w_exp = 4 * (nrr + 1) - nk;
    was_ready = ready;
    start = 1'b1;
    key_size = ks;
    key = k;
    if (was_ready) begin
      rd_en = 1'b1;
      rd_round = 4'd0;
      rd_inv = 1'b0;
      exp_q.push_back(ref_rk(cur_key, cur_nk, 0));
    end
    @(posedge clk); #1;
    start = 1'b0;
    rd_en = 1'b0;
    cur_key = k;
    cur_nk = nk;
    chk("accept_busy", busy, 1);
    chk("accept_ready", ready, 0);
    chk("accept_nr", nr, 0);
    cnt = 0;
    while (!ready && cnt < 200) begin
      if (cnt == inj) begin
        start = 1'b1;
        key_size = 2'b00;
        key = ~k;
      end
      @(posedge clk); #1;
      cnt++;
      if (start) begin
        start = 1'b0;
        chk("ignored_cfg_err", cfg_err, 0);
      end
    end
    chk("expand_cycles", cnt, w_exp);
    chk("done_busy", busy, 0);
    chk("done_nr", nr, nrr);
  endtask

  initial begin
    int cnt;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    cur_key = '0;
    cur_nk = 4;
    rst = 1'b0; start = 1'b0; key_size = 2'b00; key = '0;
    rd_en = 1'b0; rd_round = 4'd0; rd_inv = 1'b0;
    s_start = 1'b0; s_key_size = 2'b00; s_key = '0;
    s_rd_en = 1'b0; s_rd_round = 4'd0; s_rd_inv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b1;

    // 128-bit expansion and reads.
    expand(2'b00, K128, -1);
    rd(4'd10, 1'b0, 1'b1, R10_128);
    rd(4'd0, 1'b0, 1'b1, K128[255:128]);
    rd(4'd10, 1'b1, 1'b1, K128[255:128]);

    // Reserved key size is rejected; schedule survives.
    start = 1'b1;
    key_size = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rsvd_cfg_err", cfg_err, 1);
    chk("rsvd_ready", ready, 1);
    chk("rsvd_nr", nr, 10);
    @(posedge clk); #1;
    chk("rsvd_cfg_err_pulse", cfg_err, 0);
    rd(4'd10, 1'b0, 1'b1, R10_128);

    // 192-bit restart from READY with a start injected mid-expansion.
    expand(2'b01, K192, 10);
    rd(4'd12, 1'b0, 1'b1, R12_192);

    // 256-bit expansion, inverse read, forward/mirror bursts.
    expand(2'b10, K256, -1);
    rd(4'd0, 1'b1, 1'b1, R14_256);
    @(posedge clk); #1;
    max_streak = 0;
    for (int r = 0; r < 15; r++) rd(4'(r), 1'b0, 1'b1, ref_rk(K256, 8, r));
    for (int r = 0; r < 15; r++) rd(4'(r), 1'b1, 1'b1, ref_rk(K256, 8, 14 - r));
    repeat (2) @(posedge clk);
    #1;
    chk("burst_streak", max_streak, 30);
    chk("burst_drained", exp_q.size(), 0);
    rd(4'd15, 1'b0, 1'b0, '0);
    chk("rd15_valid", rk_valid, 0);

    // Reset 20 cycles into a 256-bit expansion, then a clean 128-bit run.
    start = 1'b1;
    key_size = 2'b10;
    key = K256;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_reset("midrst");
    expand(2'b00, K128, -1);
    rd(4'd10, 1'b0, 1'b1, R10_128);
    rd(4'd5, 1'b1, 1'b1, ref_rk(K128, 4, 5));

    // MAX_KEY_LEN=128 instance rejects 256-bit, accepts 128-bit.
    s_start = 1'b1;
    s_key_size = 2'b10;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("max128_cfg_err", s_cfg_err, 1);
    chk("max128_busy", s_busy, 0);
    s_start = 1'b1;
    s_key_size = 2'b00;
    s_key = K128[255:128];
    @(posedge clk); #1;
    s_start = 1'b0;
    cnt = 0;
    while (!s_ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("max128_cycles", cnt, 40);
    chk("max128_nr", s_nr, 10);
    s_rd_en = 1'b1;
    s_rd_round = 4'd10;
    @(posedge clk); #1;
    s_rd_en = 1'b0;
    chk("max128_valid", s_rk_valid, 1);
    chk("max128_rk", s_round_key, R10_128);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
